// File: rtl/length_finder_scheduler_if.sv
// length_finder_scheduler_if
//   Request/result bundle for length_finder_scheduler.
//   master : string producers and result consumer (drive req_valid, req_string, res_ready)
//   slave  : the scheduler (drives req_ready, res_valid, res_length, res_id)
//   req_valid/req_ready  per-requester handshake, one-hot grant
//   req_string           requester i string at [64*i+63 : 64*i]
//   res_valid/res_ready  result handshake; res_length 0..8, res_id = source requester
interface length_finder_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [64*NUM_REQ-1:0] req_string;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [3:0]            res_length;
  logic [ID_W-1:0]       res_id;

  modport master (
    output req_valid, req_string, res_ready,
    input  req_ready, res_valid, res_length, res_id
  );

  modport slave (
    input  req_valid, req_string, res_ready,
    output req_ready, res_valid, res_length, res_id
  );
endinterface

// File: rtl/length_finder_scheduler.sv
// length_finder_scheduler
//   Shares one combinational length finder between NUM_REQ requesters. A grant in
//   IDLE registers the winner's 64-bit string (CALC), the finder result is
//   registered and presented on the result port (HOLD) until consumed.
//   Length = index of the lowest 8'h00 byte (byte 0 = bits [7:0]), 8 if none.
// Ports
//   clk   : clock, all state on posedge
//   rst   : synchronous active-high reset
//   bus   : length_finder_scheduler_if.slave (request and result handshakes)
//   busy  : high whenever the FSM is not in IDLE
// Configuration
//   LFS_ROUND_ROBIN_EN defined   -> round-robin grant starting at rr_ptr
//   LFS_ROUND_ROBIN_EN undefined -> fixed priority, lowest asserted index wins
module length_finder_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  length_finder_scheduler_if.slave bus,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [63:0]        string_sel;
  logic [63:0]        string_q;
  logic [ID_W-1:0]    id_q;
  logic [3:0]         fl_len;
  logic               res_valid_q;
  logic [3:0]         res_length_q;
  logic [ID_W-1:0]    res_id_q;
  logic [NUM_REQ-1:0] req_ready_c;

  // ---------------- arbiter ----------------
`ifdef LFS_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  // Search order rr_ptr, rr_ptr+1, ... wrapping; rr_ptr+k hits index i either
  // directly or one lap later (i+NUM_REQ), which avoids a variable modulo index.
  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && bus.req_valid[i] &&
            ((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k == i + NUM_REQ))) begin
          grant_any   = 1'b1;
          grant_oh[i] = 1'b1;
          grant_id    = ID_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (state == IDLE && grant_any)
      rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end
`else
  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && bus.req_valid[i]) begin
        grant_any   = 1'b1;
        grant_oh[i] = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
  end
`endif

  // One-hot mux of the granted string
  always_comb begin
    string_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_oh[i]) string_sel = string_sel | bus.req_string[64*i +: 64];
  end

  // ---------------- shared length finder ----------------
  logic [7:0] zero_byte;
  for (genvar b = 0; b < 8; b++) begin : g_byte
    assign zero_byte[b] = (string_q[8*b +: 8] == 8'h00);
  end

  // Scan high to low so the lowest null byte wins
  always_comb begin
    fl_len = 4'd8;
    for (int b = 7; b >= 0; b--)
      if (zero_byte[b]) fl_len = 4'(b);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = CALC;
      CALC:    state_nxt = HOLD;
      HOLD:    if (res_valid_q && bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is only offered in IDLE; masked during reset so nobody believes
  // they were accepted on an edge that the reset discards.
  always_comb begin
    req_ready_c = '0;
    busy        = (state != IDLE);
    if (state == IDLE && !rst) req_ready_c = grant_oh;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      string_q     <= '0;
      id_q         <= '0;
      res_valid_q  <= 1'b0;
      res_length_q <= '0;
      res_id_q     <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          string_q <= string_sel;
          id_q     <= grant_id;
        end
        CALC: begin
          res_length_q <= fl_len;
          res_id_q     <= id_q;
          res_valid_q  <= 1'b1;
        end
        HOLD: if (bus.res_ready) res_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_length = res_length_q;
  assign bus.res_id     = res_id_q;

endmodule

// File: tb/tb_length_finder_scheduler.sv
// tb_length_finder_scheduler
//   Directed bench for length_finder_scheduler (NUM_REQ=4). Drives on negedge,
//   samples #1 after negedge. Expectations adapt to LFS_ROUND_ROBIN_EN.
module tb_length_finder_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic [63:0] strs [NUM_REQ];

  int n_chk = 0;
  int n_err = 0;

  length_finder_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  length_finder_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  assign bus.req_string = {strs[3], strs[2], strs[1], strs[0]};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Starts in IDLE just after a negedge; ends in IDLE just after a negedge.
  task automatic run_txn(input logic [3:0] vmask, input logic [3:0] exp_oh,
                         input logic [3:0] exp_len, input logic [1:0] exp_id,
                         input int stall, input bit drop);
    bus.req_valid = vmask;
    bus.res_ready = 1'b0;
    #1;
    chk("req_ready_idle", bus.req_ready, exp_oh);
    @(posedge clk);
    @(negedge clk);
    if (drop) bus.req_valid = vmask & ~exp_oh;
    #1;
    chk("busy_calc", busy, 1'b1);
    chk("req_ready_calc", bus.req_ready, 4'b0000);
    chk("res_valid_calc", bus.res_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("res_valid_hold", bus.res_valid, 1'b1);
    chk("res_length", bus.res_length, exp_len);
    chk("res_id", bus.res_id, exp_id);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", bus.res_valid, 1'b1);
      chk("stall_length", bus.res_length, exp_len);
      chk("stall_id", bus.res_id, exp_id);
      chk("stall_req_ready", bus.req_ready, 4'b0000);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("res_valid_done", bus.res_valid, 1'b0);
    chk("busy_done", busy, 1'b0);
    chk("length_kept", bus.res_length, exp_len);
  endtask

  initial begin
    strs[0] = 64'h0000_0000_0041_4242; // len 3
    strs[1] = 64'h4142_4344_4546_4748; // len 8
    strs[2] = 64'h0000_0000_0000_4100; // len 0
    strs[3] = 64'h0041_4141_4141_4141; // len 7

    // reset state
    do_reset();
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_length", bus.res_length, 4'd0);
    chk("rst_res_id", bus.res_id, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", bus.req_ready, 4'b0000);

    // 1: basic length 3 from requester 0
    run_txn(4'b0001, 4'b0001, 4'd3, 2'd0, 0, 1'b1);

    // 2: no null -> 8, null at byte 0 -> 0
    strs[0] = 64'h4142_4344_4546_4748;
    run_txn(4'b0001, 4'b0001, 4'd8, 2'd0, 0, 1'b1);
    strs[0] = 64'h0000_0000_0000_4100;
    run_txn(4'b0001, 4'b0001, 4'd0, 2'd0, 0, 1'b1);
    strs[0] = 64'h1111_0011_2233_4455; // null at byte 5
    run_txn(4'b0001, 4'b0001, 4'd5, 2'd0, 0, 1'b1);
    strs[0] = 64'h0000_0000_0041_4242;

    // 4: consumer stalls 5 cycles in HOLD
    run_txn(4'b0010, 4'b0010, 4'd8, 2'd1, 5, 1'b1);

    // 3: all requesters held valid from rr_ptr=0
    do_reset();
`ifdef LFS_ROUND_ROBIN_EN
    run_txn(4'b1111, 4'b0001, 4'd3, 2'd0, 0, 1'b0);
    run_txn(4'b1111, 4'b0010, 4'd8, 2'd1, 0, 1'b0);
    run_txn(4'b1111, 4'b0100, 4'd0, 2'd2, 0, 1'b0);
    run_txn(4'b1111, 4'b1000, 4'd7, 2'd3, 0, 1'b0);
    run_txn(4'b1111, 4'b0001, 4'd3, 2'd0, 0, 1'b0);
`else
    for (int n = 0; n < 4; n++)
      run_txn(4'b1111, 4'b0001, 4'd3, 2'd0, 0, 1'b0);
`endif
    bus.req_valid = '0;

    // 5: reset pulse mid-CALC aborts requester 2
    @(negedge clk);
    bus.req_valid = 4'b0100;
    #1;
    chk("abort_grant", bus.req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("abort_busy_calc", busy, 1'b1);
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_res_valid", bus.res_valid, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      chk("abort_no_result", bus.res_valid, 1'b0);
    end
    // rr_ptr back at 0: {3,2} requesting -> 2 wins in both builds
    run_txn(4'b1100, 4'b0100, 4'd0, 2'd2, 0, 1'b1);
    bus.req_valid = '0;

    // 6: requester 1 withdraws while busy; requester 3 granted afterwards
    @(negedge clk);
    bus.req_valid = 4'b0001;
    #1;
    chk("w_grant0", bus.req_ready, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 4'b1010;
    @(negedge clk);
    #1;
    chk("w_hold_valid", bus.res_valid, 1'b1);
    chk("w_hold_req_ready", bus.req_ready, 4'b0000);
    bus.req_valid = 4'b1000;
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    run_txn(4'b1000, 4'b1000, 4'd7, 2'd3, 0, 1'b1);
    bus.req_valid = '0;

    // res_ready in IDLE has no effect
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_res_ready", busy, 1'b0);
    bus.res_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
